// File: rtl/alu_seq_pkg.sv
// Shared opcode/state types and auto-sequencer constants for the handshaked
// sequential ALU.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_INC = 3'd1,
    OP_SUB = 3'd2,
    OP_DEC = 3'd3,
    OP_MUL = 3'd4,
    OP_SHR = 3'd5,
    OP_SHL = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_CNT_WRAP = 3'd6;

  // Auto-sequence skips the reserved opcode by wrapping after SHL.
  function automatic logic [2:0] next_op_cnt(input logic [2:0] cnt);
    return (cnt == OP_CNT_WRAP) ? 3'd0 : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// LSB first; done pulses the cycle after the final iteration.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int MUL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*MUL_W-1:0]   product
);

  localparam int CW = $clog2(MUL_W + 1);

  logic [2*MUL_W-1:0] mcand_q;
  logic [2*MUL_W-1:0] acc_q;
  logic [MUL_W-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q  <= {{MUL_W{1'b0}}, a};
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= CW'(MUL_W);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one operation in flight, explicit or
// auto-sequenced opcode, iterative multiply, registered result and flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_W = WIDTH / 2,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             auto_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [2:0]       op_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  state_e           state_q;
  op_e              opc_q;
  op_e              op_out_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [2:0]       cnt_q;
  logic             in_ready_q, out_valid_q;
  logic             z_q, c_q, v_q, err_q;

  op_e              eff_op;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0] alu_res, opnd;
  logic [WIDTH:0]   sum_w;
  logic             alu_c, alu_v, alu_err;

  assign eff_op    = op_e'(auto_mode ? cnt_q : op);
  // Multiplier starts on the accept edge itself so its last iteration lines
  // up with a MUL_W+1 cycle accept-to-valid latency.
  assign mul_start = (state_q == S_IDLE) && in_valid && (eff_op == OP_MUL);

  alu_seq_mul #(.MUL_W(MUL_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a[MUL_W-1:0]),
    .b       (b[MUL_W-1:0]),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum_w   = '0;
    opnd    = ((opc_q == OP_INC) || (opc_q == OP_DEC)) ? ONE_V : b_q;
    case (opc_q)
      OP_ADD, OP_INC: begin
        sum_w   = {1'b0, a_q} + {1'b0, opnd};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a_q[WIDTH-1] == opnd[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = a_q - opnd;
        alu_c   = a_q < opnd;
        alu_v   = (a_q[WIDTH-1] != opnd[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SHR:  alu_res = (b_q >= WIDTH_V) ? '0 : a_q >> b_q[SH_W-1:0];
      OP_SHL:  alu_res = (b_q >= WIDTH_V) ? '0 : a_q << b_q[SH_W-1:0];
      OP_RSV:  alu_err = 1'b1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opc_q       <= OP_ADD;
      op_out_q    <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            opc_q      <= eff_op;
            in_ready_q <= 1'b0;
            if (auto_mode) begin
              cnt_q <= next_op_cnt(cnt_q);
            end
            state_q <= (eff_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_q         <= alu_res;
          z_q         <= (alu_res == '0);
          c_q         <= alu_c;
          v_q         <= alu_v;
          err_q       <= alu_err;
          op_out_q    <= opc_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_MUL: begin
          if (mul_done && !mul_busy) begin
            r_q         <= mul_prod;
            z_q         <= (mul_prod == '0);
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            op_out_q    <= OP_MUL;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign op_out    = op_out_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W  = 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          auto_mode = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          in_ready, out_valid, flag_z, flag_c, flag_v, err;
  logic [W-1:0]  r;
  logic [2:0]    op_out;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .auto_mode (auto_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .op_out    (op_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Returns {r, z, c, v, err} computed from the opcode's arithmetic meaning.
  function automatic logic [W+3:0] model(input int opc, input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W-1:0]    rr = '0;
    logic [W-1:0]    y;
    logic            c = 1'b0, v = 1'b0, e = 1'b0;
    longint          s;
    longint unsigned u;
    y = (opc == 1 || opc == 3) ? 32'd1 : mb;
    case (opc)
      0, 1: begin
        u  = longint'(ma) + longint'(y);
        rr = u[31:0];
        c  = u[32];
        s  = longint'($signed(ma)) + longint'($signed(y));
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2, 3: begin
        rr = ma - y;
        c  = (ma < y);
        s  = longint'($signed(ma)) - longint'($signed(y));
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4: rr = {16'h0, ma[15:0]} * {16'h0, mb[15:0]};
      5: rr = (mb >= 32) ? 32'h0 : (ma >> mb);
      6: rr = (mb >= 32) ? 32'h0 : (ma << mb);
      default: e = 1'b1;
    endcase
    return {rr, (rr == 32'h0), c, v, e};
  endfunction

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int top,
                       input bit am, output int eop);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    eop = am ? model_cnt : top;
    if (am) model_cnt = (model_cnt == 6) ? 0 : model_cnt + 1;
    a = ta; b = tb_; op = top[2:0]; auto_mode = am; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom); auto_mode = 1'($urandom);
  endtask

  task automatic await_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, r, op_out, flag_z, flag_c, flag_v, err} !== {1'b1, 1'b0, 32'h0, 3'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b r=%h op=%0d f=%b%b%b%b, want rdy=1 vld=0 r=0 op=0 f=0000",
               in_ready, out_valid, r, op_out, flag_z, flag_c, flag_v, err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_flags();
    int eop, lat;
    issue(32'hFFFF_FFFF, 32'h1, 0, 1'b0, eop);
    await_out(lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d want 1", lat); end
    vectors++;
    if ({r, flag_z, flag_c, flag_v, err, op_out} !== {32'h0, 4'b1100, 3'd0}) begin
      miscompares++;
      $display("FAIL add_wrap: got r=%h zcve=%b%b%b%b op=%0d want r=0 zcve=1100 op=0", r, flag_z, flag_c, flag_v, err, op_out);
    end
    consume();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL add_handshake: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_sub_dec();
    int eop, lat;
    issue(32'h8000_0000, 32'h1, 2, 1'b0, eop);
    await_out(lat);
    vectors++;
    if ({r, flag_z, flag_c, flag_v, err, op_out} !== {32'h7FFF_FFFF, 4'b0010, 3'd2}) begin
      miscompares++;
      $display("FAIL sub_ovf: got r=%h zcve=%b%b%b%b op=%0d want r=7fffffff zcve=0010 op=2", r, flag_z, flag_c, flag_v, err, op_out);
    end
    consume();
    issue(32'h0, 32'h1234_5678, 3, 1'b0, eop);
    await_out(lat);
    vectors++;
    if ({r, flag_z, flag_c, flag_v, err, op_out} !== {32'hFFFF_FFFF, 4'b0100, 3'd3}) begin
      miscompares++;
      $display("FAIL dec_borrow: got r=%h zcve=%b%b%b%b op=%0d want r=ffffffff zcve=0100 op=3", r, flag_z, flag_c, flag_v, err, op_out);
    end
    consume();
  endtask

  task automatic test_mul();
    int eop, lat = 0, rdy_hi = 0;
    issue(32'h0000_FFFF, 32'h0000_FFFF, 4, 1'b0, eop);
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== MW + 1) begin miscompares++; $display("FAIL mul_latency: got %0d want %0d", lat, MW + 1); end
    vectors++;
    if (rdy_hi !== 0) begin miscompares++; $display("FAIL mul_in_ready: got %0d ready cycles want 0", rdy_hi); end
    vectors++;
    if ({r, flag_z, flag_c, flag_v, err, op_out} !== {32'hFFFE_0001, 4'b0000, 3'd4}) begin
      miscompares++;
      $display("FAIL mul_max: got r=%h zcve=%b%b%b%b op=%0d want r=fffe0001 zcve=0000 op=4", r, flag_z, flag_c, flag_v, err, op_out);
    end
    consume();
  endtask

  task automatic test_shifts_rsv();
    int eop, lat;
    logic [W+6:0] exp_t [4];
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    int           so [4];
    sa = '{32'h1, 32'h8000_0000, 32'h1, 32'hDEAD_BEEF};
    sb = '{32'd31, 32'd32, 32'd33, 32'h5};
    so = '{6, 5, 6, 7};
    exp_t = '{{32'h8000_0000, 4'b0000, 3'd6}, {32'h0, 4'b1000, 3'd5},
              {32'h0, 4'b1000, 3'd6}, {32'h0, 4'b1001, 3'd7}};
    for (int i = 0; i < 4; i++) begin
      issue(sa[i], sb[i], so[i], 1'b0, eop);
      await_out(lat);
      vectors++;
      if ({r, flag_z, flag_c, flag_v, err, op_out} !== exp_t[i] || lat !== 1) begin
        miscompares++;
        $display("FAIL shift_rsv[%0d]: got r=%h zcve=%b%b%b%b op=%0d lat=%0d want %h lat=1",
                 i, r, flag_z, flag_c, flag_v, err, op_out, lat, exp_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int eop, lat;
    logic [W-1:0] held;
    int exp_r [8] = '{9, 7, 3, 5, 18, 0, 48, 9};
    int exp_o [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    for (int i = 0; i < 8; i++) begin
      issue(32'd6, 32'd3, int'($urandom_range(0, 7)), 1'b1, eop);
      await_out(lat);
      vectors++;
      if (r !== W'(exp_r[i]) || op_out !== 3'(exp_o[i]) || lat !== ((exp_o[i] == 4) ? MW + 1 : 1)) begin
        miscompares++;
        $display("FAIL auto_seq[%0d]: got r=%0d op=%0d lat=%0d want r=%0d op=%0d", i, r, op_out, lat, exp_r[i], exp_o[i]);
      end
      consume();
    end
    out_ready = 1'b0;
    issue(32'd100, 32'd23, 0, 1'b0, eop);
    await_out(lat);
    held = r;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || r !== 32'd123 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b r=%0d want vld=1 rdy=0 r=123 (first r=%0d)", i, out_valid, in_ready, r, held);
      end
    end
    consume();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int eop, lat;
    issue(32'h1234, 32'h5678, 4, 1'b0, eop);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    model_cnt = 0;
    #1;
    vectors++;
    if ({in_ready, out_valid, r, op_out, flag_z, flag_c, flag_v, err} !== {1'b1, 1'b0, 32'h0, 3'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got rdy=%b vld=%b r=%h op=%0d f=%b%b%b%b want rdy=1 vld=0 r=0 op=0 f=0000",
               in_ready, out_valid, r, op_out, flag_z, flag_c, flag_v, err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd2, 32'd3, 6, 1'b1, eop);
    await_out(lat);
    vectors++;
    if (r !== 32'd5 || op_out !== 3'd0 || lat !== 1) begin
      miscompares++;
      $display("FAIL post_reset_add: got r=%0d op=%0d lat=%0d want r=5 op=0 lat=1", r, op_out, lat);
    end
    consume();
  endtask

  task automatic test_random();
    int eop, lat, top, hold;
    bit am;
    logic [W-1:0] ta, tb_;
    logic [W+3:0] exp_v;
    for (int i = 0; i < 60; i++) begin
      top = int'($urandom_range(0, 7));
      am  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       begin ta = $urandom; tb_ = W'($urandom_range(0, 40)); end
        1:       begin ta = 32'hFFFF_FFFF; tb_ = $urandom_range(0, 1) ? 32'h1 : 32'h8000_0000; end
        2:       begin ta = 32'h7FFF_FFFF ^ W'($urandom_range(0, 1)); tb_ = $urandom; end
        default: begin ta = $urandom; tb_ = $urandom; end
      endcase
      hold = int'($urandom_range(0, 2));
      out_ready = (hold == 0);
      issue(ta, tb_, top, am, eop);
      exp_v = model(eop, ta, tb_);
      await_out(lat);
      repeat (hold) begin @(posedge clk); #1; end
      vectors++;
      if ({r, flag_z, flag_c, flag_v, err} !== exp_v || op_out !== 3'(eop) ||
          lat !== ((eop == 4) ? MW + 1 : 1)) begin
        miscompares++;
        $display("FAIL random[%0d]: op=%0d a=%h b=%h got r=%h zcve=%b%b%b%b op_out=%0d lat=%0d want r=%h zcve=%b",
                 i, eop, ta, tb_, r, flag_z, flag_c, flag_v, err, op_out, lat, exp_v[W+3:4], exp_v[3:0]);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_sub_dec();
    test_mul();
    test_shifts_rsv();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
